// File: rtl/lrn_pkg.sv
// rtl/lrn_pkg.sv - shared state type, defaults and width helper for the LRN window buffer
package lrn_pkg;

  typedef enum logic [2:0] {
    FILL,
    PRIME,
    ISSUE,
    DRAIN,
    DONE
  } lrn_state_t;

  localparam int LRN_LOCAL_HALF = 2;

  // Width that holds the sum of squares over a full 2*local_half+1 window.
  function automatic int lrn_sum_width(input int data_width, input int local_half);
    return 2 * data_width + $clog2(2 * local_half + 1);
  endfunction

endpackage

// File: rtl/lrn_square.sv
// rtl/lrn_square.sv - registered signed-to-unsigned squarer, one cycle latency
module lrn_square #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          core_clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  output logic [2*DATA_WIDTH-1:0]       sq
);

  logic signed [2*DATA_WIDTH-1:0] in_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // The square of any signed value fits in 2*DATA_WIDTH-1 bits, so the
  // truncated product is always the exact, non-negative result.
  assign in_ext = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
  assign prod   = in_ext * in_ext;

  // Register the square so it lands in sq_mem one cycle after the element.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) sq <= '0;
    else       sq <= $unsigned(prod);
  end

endmodule

// File: rtl/lrn_window_buffer.sv
// rtl/lrn_window_buffer.sv - buffers one channel column and streams (x[c], windowed sum of squares) to a divider
module lrn_window_buffer
  import lrn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int M_WIDTH    = 10,
  parameter int DEPTH      = 64,
  parameter int LOCAL_HALF = LRN_LOCAL_HALF,
  localparam int SUM_WIDTH = lrn_sum_width(DATA_WIDTH, LOCAL_HALF)
) (
  input  logic                          core_clk,
  input  logic                          reset,
  input  logic [M_WIDTH-1:0]            dim3,
  input  logic                          rd_valid,
  input  logic signed [DATA_WIDTH-1:0]  rd_data,
  output logic                          div_in_valid,
  input  logic                          div_in_ready,
  output logic signed [DATA_WIDTH-1:0]  div_numerator,
  output logic [SUM_WIDTH-1:0]          div_sum_sq,
  input  logic                          div_out_valid,
  output logic                          full_flag,
  output logic                          normalized_window,
  output logic                          overflow_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int IW  = M_WIDTH + 2;
  localparam int SQW = 2 * DATA_WIDTH;

  lrn_state_t              state;
  logic [DATA_WIDTH-1:0]   x_mem  [DEPTH];
  logic [SQW-1:0]          sq_mem [DEPTH];
  logic [AW-1:0]           wr_ptr, c, p_idx, sq_wr_addr;
  logic                    sq_wr_en;
  logic [M_WIDTH-1:0]      dim_q, res_cnt;
  logic [SUM_WIDTH-1:0]    sum;
  logic [SQW-1:0]          sq_new;

  logic [M_WIDTH-1:0]      dim_cur;
  logic                    dim_bad, wr_accept, last_wr, xfer, last_xfer;
  logic [IW-1:0]           c_w, add_idx, prime_last;
  logic [SQW-1:0]          prime_sq, add_sq, sub_sq;
  logic [SUM_WIDTH-1:0]    prime_sum, next_sum;

  lrn_square #(.DATA_WIDTH(DATA_WIDTH)) u_square (
    .core_clk (core_clk),
    .reset    (reset),
    .in_data  (rd_data),
    .sq       (sq_new)
  );

  // dim3 is live only for the first element of a column; afterwards the sampled copy rules.
  assign dim_cur   = (wr_ptr == '0) ? dim3 : dim_q;
  assign dim_bad   = (dim_cur == '0) || (IW'(dim_cur) > IW'(DEPTH));
  assign wr_accept = rd_valid && (state == FILL) && !full_flag && !dim_bad;
  assign last_wr   = (IW'(wr_ptr) + IW'(1)) == IW'(dim_cur);

  // The last square is still in flight during the first PRIME cycle, so bypass it.
  assign prime_sq   = (sq_wr_en && (sq_wr_addr == p_idx)) ? sq_new : sq_mem[p_idx];
  assign prime_last = (IW'(dim_q) > IW'(LOCAL_HALF)) ? IW'(LOCAL_HALF) : IW'(dim_q) - IW'(1);
  assign prime_sum  = sum + SUM_WIDTH'(prime_sq);

  // Sliding window: drop the channel leaving on the left before adding the one entering
  // on the right, so the running sum never exceeds a full window.
  assign c_w       = IW'(c);
  assign add_idx   = c_w + IW'(LOCAL_HALF + 1);
  assign add_sq    = (add_idx < IW'(dim_q)) ? sq_mem[add_idx[AW-1:0]] : '0;
  assign sub_sq    = (c_w >= IW'(LOCAL_HALF)) ? sq_mem[c - AW'(LOCAL_HALF)] : '0;
  assign next_sum  = sum - SUM_WIDTH'(sub_sq) + SUM_WIDTH'(add_sq);
  assign xfer      = div_in_valid && div_in_ready;
  assign last_xfer = (c_w + IW'(1)) == IW'(dim_q);

  // Column storage: element on accept, its square one cycle later.
  always_ff @(posedge core_clk) begin
    if (wr_accept) x_mem[wr_ptr] <= rd_data;
    if (sq_wr_en)  sq_mem[sq_wr_addr] <= sq_new;
  end

  // Control FSM with registered divider payload and status flags.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state             <= FILL;
      wr_ptr            <= '0;
      c                 <= '0;
      p_idx             <= '0;
      sum               <= '0;
      res_cnt           <= '0;
      dim_q             <= '0;
      sq_wr_en          <= 1'b0;
      sq_wr_addr        <= '0;
      div_in_valid      <= 1'b0;
      div_numerator     <= '0;
      div_sum_sq        <= '0;
      full_flag         <= 1'b0;
      normalized_window <= 1'b0;
      overflow_err      <= 1'b0;
    end else begin
      sq_wr_en          <= wr_accept;
      sq_wr_addr        <= wr_ptr;
      normalized_window <= 1'b0;

      if (rd_valid && ((state != FILL) || full_flag || dim_bad)) overflow_err <= 1'b1;

      if (div_out_valid) begin
        if (((state == ISSUE) || (state == DRAIN)) && (res_cnt < dim_q))
          res_cnt <= res_cnt + M_WIDTH'(1);
        else
          overflow_err <= 1'b1;
      end

      case (state)
        FILL: begin
          if (wr_accept) begin
            if (wr_ptr == '0) dim_q <= dim3;
            if (last_wr) begin
              wr_ptr    <= '0;
              p_idx     <= '0;
              sum       <= '0;
              full_flag <= 1'b1;
              state     <= PRIME;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        PRIME: begin
          sum   <= prime_sum;
          p_idx <= p_idx + AW'(1);
          if (IW'(p_idx) == prime_last) begin
            c             <= '0;
            div_in_valid  <= 1'b1;
            div_numerator <= x_mem[0];
            div_sum_sq    <= prime_sum;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            sum <= next_sum;
            c   <= c + AW'(1);
            if (last_xfer) begin
              div_in_valid <= 1'b0;
              state        <= DRAIN;
            end else begin
              div_numerator <= x_mem[c + AW'(1)];
              div_sum_sq    <= next_sum;
            end
          end
        end
        DRAIN: begin
          if (res_cnt == dim_q) begin
            normalized_window <= 1'b1;
            full_flag         <= 1'b0;
            state             <= DONE;
          end
        end
        DONE: begin
          wr_ptr  <= '0;
          c       <= '0;
          p_idx   <= '0;
          sum     <= '0;
          res_cnt <= '0;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
